// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter shared package
// Channel widths, state encoding and reset constants.
package calab3_pkg;

  localparam int CH_W   = 2;
  localparam int NUM_CH = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CH_W-1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter handshake bundle
// master = producers/consumer side, slave = arbiter side.
interface mux4_rr_arbiter_if
  import calab3_pkg::*;
#(
  parameter int N = 8
) ();

  logic [NUM_CH-1:0] in_valid;
  logic [N-1:0]      in_data0;
  logic [N-1:0]      in_data1;
  logic [N-1:0]      in_data2;
  logic [N-1:0]      in_data3;
  logic [NUM_CH-1:0] in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_data;
  logic [CH_W-1:0]   sel;

  modport master (
    output in_valid,
    output in_data0,
    output in_data1,
    output in_data2,
    output in_data3,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  sel
  );

  modport slave (
    input  in_valid,
    input  in_data0,
    input  in_data1,
    input  in_data2,
    input  in_data3,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output sel
  );

endinterface

// File: rtl/mux4_rr_arbiter_grant.sv
// rr_grant4: combinational round-robin pick
// First request found searching last+1 .. last+4 (mod 4).
module rr_grant4
  import calab3_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_any
);

  logic [CH_W-1:0] cand;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = last + CH_W'(i);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter top: 4-channel RR arbiter
// with a one-word output register and mux select.
module mux4_rr_arbiter
  import calab3_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux4_rr_arbiter_if.slave    bus
);

  state_t          state_q;
  logic [CH_W-1:0] last_q;
  logic [N-1:0]    data_q;
  logic [CH_W-1:0] sel_q;

  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            open;
  logic            take;
  logic [N-1:0]    pick;

  rr_grant4 u_grant (
    .req     (bus.in_valid),
    .last    (last_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign open = (state_q == EMPTY) | bus.out_ready;
  assign take = open & gnt_any;

  assign bus.in_ready =
    take ? NUM_CH'(4'b0001 << gnt_idx) : '0;

  always_comb begin
    pick = '0;
    unique case (gnt_idx)
      2'd0: pick = bus.in_data0;
      2'd1: pick = bus.in_data1;
      2'd2: pick = bus.in_data2;
      2'd3: pick = bus.in_data3;
      default: pick = '0;
    endcase
  end

  // Drain and refill share one edge for full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_q  <= LAST_RST;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (take) begin
      state_q <= FULL;
      last_q  <= gnt_idx;
      data_q  <= pick;
      sel_q   <= gnt_idx;
    end else if (state_q == FULL && bus.out_ready) begin
      state_q <= EMPTY;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed vectors, queue
// scoreboard checked by an independent monitor.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [9:0] sb[$];

  mux4_rr_arbiter_if #(.N(8)) bus ();

  mux4_rr_arbiter #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request vector, check in_ready, queue expected word.
  task automatic grant(input logic [3:0] v,
                       input logic [3:0] rdy,
                       input logic [1:0] s,
                       input logic [7:0] d);
    bus.in_valid = v;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(rdy));
    if (rdy != 4'b0000)
      sb.push_back({s, d});
    #0;
    tick();
  endtask

  task automatic out_chk(input string name,
                         input logic       v,
                         input logic [1:0] s,
                         input logic [7:0] d);
    check({name, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({name, ".sel"}, 32'(bus.sel), 32'(s));
    check({name, ".data"}, 32'(bus.out_data), 32'(d));
  endtask

  // Monitor: a word is consumed at the edge after this sample.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb.unexpected", 32'(bus.out_data), 32'hFFFF);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check("sb.sel", 32'(bus.sel), 32'(e[9:8]));
        check("sb.data", 32'(bus.out_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n        = 1'b0;
    bus.in_valid = 4'b0000;
    bus.in_data0 = 8'h00;
    bus.in_data1 = 8'h00;
    bus.in_data2 = 8'h00;
    bus.in_data3 = 8'h00;
    bus.out_ready = 1'b0;

    // Reset, then idle
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      out_chk("idle", 1'b0, 2'd0, 8'h00);
      check("idle.in_ready", 32'(bus.in_ready), 32'h0);
      tick();
    end

    // Rotation
    bus.in_data0 = 8'h00;
    bus.in_data1 = 8'h01;
    bus.in_data2 = 8'h02;
    bus.in_data3 = 8'h03;
    bus.out_ready = 1'b1;
    grant(4'b1111, 4'b0001, 2'd0, 8'h00);
    grant(4'b1111, 4'b0010, 2'd1, 8'h01);
    grant(4'b1111, 4'b0100, 2'd2, 8'h02);
    grant(4'b1111, 4'b1000, 2'd3, 8'h03);
    grant(4'b1111, 4'b0001, 2'd0, 8'h00);
    grant(4'b0000, 4'b0000, 2'd0, 8'h00);
    #1;
    check("rot.empty", 32'(bus.out_valid), 32'h0);

    // Backpressure
    bus.out_ready = 1'b0;
    bus.in_data0 = 8'h10;
    grant(4'b0001, 4'b0001, 2'd0, 8'h10);
    bus.in_data1 = 8'h11;
    bus.in_data2 = 8'h12;
    bus.in_valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.in_ready", 32'(bus.in_ready), 32'h0);
      out_chk("bp.hold", 1'b1, 2'd0, 8'h10);
      tick();
    end
    bus.out_ready = 1'b1;
    grant(4'b0110, 4'b0010, 2'd1, 8'h11);
    grant(4'b0110, 4'b0100, 2'd2, 8'h12);

    // Wrap and skip: last=2, channel 3 absent
    bus.in_data0 = 8'h20;
    bus.in_data1 = 8'h21;
    grant(4'b0011, 4'b0001, 2'd0, 8'h20);
    grant(4'b0011, 4'b0010, 2'd1, 8'h21);
    grant(4'b0000, 4'b0000, 2'd0, 8'h00);

    // Drain to empty
    bus.in_data2 = 8'hA5;
    grant(4'b0100, 4'b0100, 2'd2, 8'hA5);
    bus.in_valid = 4'b0000;
    out_chk("drain.full", 1'b1, 2'd2, 8'hA5);
    tick();
    out_chk("drain.empty", 1'b0, 2'd2, 8'hA5);

    // Reset mid-operation drops the held word
    bus.out_ready = 1'b0;
    bus.in_data3 = 8'h5A;
    grant(4'b1000, 4'b1000, 2'd3, 8'h5A);
    bus.in_valid = 4'b0000;
    out_chk("pre_rst", 1'b1, 2'd3, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    out_chk("mid_rst", 1'b0, 2'd0, 8'h00);
    check("mid_rst.in_ready", 32'(bus.in_ready), 32'h0);
    check("mid_rst.sb", 32'(sb.size()), 32'd1);
    sb.delete();
    tick();
    rst_n = 1'b1;
    bus.in_data0 = 8'h30;
    bus.in_data1 = 8'h31;
    bus.in_data2 = 8'h32;
    bus.in_data3 = 8'h33;
    bus.out_ready = 1'b1;
    grant(4'b1111, 4'b0001, 2'd0, 8'h30);
    bus.in_valid = 4'b0000;
    out_chk("post_rst", 1'b1, 2'd0, 8'h30);
    tick();
    tick();

    check("sb.left", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Four-channel round-robin arbiter and output register that sits upstream of the 4:1 select mux. It accepts N-bit words from four valid/ready producers and grants one per transfer with rotating fairness. It registers the granted word and its channel index, and drives the index as the mux select `sel`. It presents the word to a single downstream consumer over a valid/ready handshake.

## Interface
- `N`, default 8: data width of every channel and of `out_data`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in_valid`  in  4: bit k high means channel k offers `in_data<k>`.
- `in_data0`..`in_data3`  in  N each: channel payloads.
- `in_ready`  out  4: one-hot or zero; bit k high means channel k's word is taken at this edge.
- `out_valid`  out  1: `out_data` and `sel` hold a word.
- `out_ready`  in  1: consumer accepts the word at this edge.
- `out_data`  out  N: registered granted word.
- `sel`  out  2: registered index of the channel that supplied `out_data`; drives the 4:1 mux select.

## Operation
- State: `EMPTY` (`out_valid`=0) or `FULL` (`out_valid`=1). `last` is a 2-bit register holding the most recently granted channel.
- Input slot is open when the state is `EMPTY`, or when the state is `FULL` and `out_ready`=1.
- When the slot is open and any `in_valid` is set, grant channel g:
  - g is the first set bit searching `last+1`, `last+2`, `last+3`, `last+4` (mod 4).
  - `in_ready[g]`=1 combinationally, and no other bit is set.
- On a granted edge:
  - `out_data` <= `in_data<g>`, `sel` <= g, `last` <= g.
  - State becomes or stays `FULL`.
- In `FULL` with `out_ready`=1 and no `in_valid` set, state goes to `EMPTY`. `out_data` and `sel` hold their last values.
- In `FULL` with `out_ready`=0, `in_ready`=0000 and all registers hold.
- Index arithmetic is 2-bit unsigned with natural wrap: 3+1 = 0.
- A channel that drops `in_valid` before being granted loses nothing and is not granted.
- Producer rule: a channel holds `in_data` stable while `in_valid` is high and it is not granted.
- `in_valid` changing while `in_ready` is low is legal.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `sel`=0, `last`=3, state `EMPTY`, `in_ready`=0000.
  - Because `last`=3, channel 0 has first priority after reset.
- Assertion of `rst_n` mid-transfer clears all state immediately. The held word is dropped.
- Release of `rst_n` is synchronised by the integrator; the first grant can occur on the first edge after release.
- Latency: word granted at edge t appears on `out_data`/`sel` with `out_valid`=1 after edge t.
- Throughput: one word per cycle when `out_ready` stays high. Simultaneous drain and grant in the same cycle is required, not optional.
- `in_ready` is combinational from `in_valid`, `out_ready`, state and `last`. There is no combinational path from `in_data` to any output.
- `out_valid`, `out_data`, `sel` are driven only from flops.

## Structure
- Shared package `calab3_pkg`:
  - `CH_W`=2 and `NUM_CH`=4.
  - State enum `{EMPTY, FULL}`.
  - Reset constant for `last` (`LAST_RST`=2'd3).
- Sub-module `rr_grant4`: purely combinational, inputs `req[3:0]` and `last[1:0]`, outputs `gnt_idx[1:0]` and `gnt_any`.
- Top holds the state, `last`, `out_data` and `sel` registers, plus the 4:1 payload select feeding `out_data`.

## Test plan
- Reset, then idle: `rst_n` low 2 cycles, release, all `in_valid`=0 → `out_valid`=0, `sel`=0, `out_data`=0x00, `in_ready`=0000 every cycle.
- Rotation: `in_valid`=1111, `in_data0..3`=0x00,0x01,0x02,0x03, `out_ready`=1 held → grants 0,1,2,3,0 on consecutive cycles; `sel` sequence 0,1,2,3,0; `out_data` 0x00,0x01,0x02,0x03,0x00.
- Backpressure: one word held with `out_ready`=0 for 3 cycles, `in_valid`=0110 → `in_ready`=0000 throughout; `out_data`/`sel` unchanged. Then `out_ready`=1 → channel 1 granted that edge.
- Wrap and skip: `last`=2, `in_valid`=0011 → grant channel 0 (`sel`=0), then channel 1. Channel 3 absent, so there is no stall.
- Drain to empty: single word 0xA5 on channel 2, then `in_valid`=0000 with `out_ready`=1 → `out_valid` falls one cycle after acceptance; `sel` stays 2, `out_data` stays 0xA5.
- Reset mid-operation: `out_valid`=1 with 0x5A, assert `rst_n` low between edges → `out_valid`=0 and `out_data`=0x00 immediately. After release, `in_valid`=1111 → first grant is channel 0.
